ctrl_pipe_chain: RTL and testbench

CTRL_PIPE_CHAIN -- requirements
Module: ctrl_pipe_chain

---
 rtl/ctrl_pipe_chain.sv | 85 ++++++++
 tb/tb_ctrl_pipe_chain.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_chain.sv
// Chain of STAGES control-bundle registers that move one stage per cycle. It has flush/stall priority and bubble insertion.
// A stall holds its own stage and every earlier stage, and in_ready drops while stage 0 is held.
module ctrl_pipe_chain #(
  parameter int WIDTH  = 29,
  parameter int STAGES = 3,
  localparam int CntW  = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  input  logic                     flush_all,
  output logic [STAGES*WIDTH-1:0]  out_data,
  output logic [STAGES-1:0]        out_valid,
  output logic [CntW-1:0]          out_count,
  output logic [31:0]              retire_cnt
);

  logic [STAGES-1:0] held;
  logic              retireFire;
  logic [31:0]       retireCnt;

  // A stall at stage k also freezes everything upstream of k.
  always_comb begin
    held = '0;
    held[STAGES-1] = stall[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      held[i] = stall[i] | held[i+1];
    end
  end

  assign in_ready = ~held[0];

  for (genvar i = 0; i < STAGES; i++) begin : gStage
    logic [WIDTH-1:0] dat;
    logic             vld;
    logic [WIDTH-1:0] loadDat;
    logic             loadVld;

    if (i == 0) begin : gHead
      assign loadVld = in_valid;
      assign loadDat = in_valid ? in_data : '0;
    end else begin : gTail
      // A held predecessor leaves a bubble behind rather than a duplicate.
      assign loadVld = out_valid[i-1] & ~held[i-1];
      assign loadDat = loadVld ? out_data[(i-1)*WIDTH +: WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
      if (!rst || flush_all || flush[i]) begin
        dat <= '0;
        vld <= 1'b0;
      end else if (!held[i]) begin
        dat <= loadDat;
        vld <= loadVld;
      end
    end

    assign out_data[i*WIDTH +: WIDTH] = dat;
    assign out_valid[i]               = vld;
  end

  always_comb begin
    out_count = '0;
    for (int i = 0; i < STAGES; i++) begin
      out_count = out_count + CntW'(out_valid[i]);
    end
  end

  assign retireFire = out_valid[STAGES-1] & ~held[STAGES-1] & ~flush[STAGES-1] & ~flush_all;

  always_ff @(posedge clk) begin
    if (!rst) begin
      retireCnt <= '0;
    end else if (retireFire) begin
      retireCnt <= retireCnt + 32'd1;
    end
  end

  assign retire_cnt = retireCnt;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain (WIDTH=29, STAGES=3).
// Bundles that should retire are queued when they are driven and compared as they reach the last stage.
module tb_ctrl_pipe_chain;
  localparam int W = 29;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   inData;
  logic           inValid;
  logic           inReady;
  logic [S-1:0]   stall;
  logic [S-1:0]   flush;
  logic           flushAll;
  logic [S*W-1:0] outData;
  logic [S-1:0]   outValid;
  logic [1:0]     outCount;
  logic [31:0]    retireCnt;

  logic [W-1:0]   sb[$];
  int             checks = 0;
  int             errors = 0;

  localparam logic [W-1:0] A = 29'h1AAAAAAA;
  localparam logic [W-1:0] B = 29'h0BBBBBBB;
  localparam logic [W-1:0] C = 29'h0CCCCCCC;
  localparam logic [W-1:0] D = 29'h1DDDDDDD;

  ctrl_pipe_chain #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReady),
    .stall(stall), .flush(flush), .flush_all(flushAll),
    .out_data(outData), .out_valid(outValid), .out_count(outCount), .retire_cnt(retireCnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h, wanted %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] stg(input int k);
    return outData[k*W +: W];
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d);
    inValid = v;
    inData  = d;
  endtask

  // Push a bundle that is expected to retire in order.
  task automatic push(input logic [W-1:0] d);
    sb.push_back(d);
  endtask

  // Compare the bundle that is now present in the last stage against the oldest queued bundle.
  task automatic popCheck(input string tag);
    logic [W-1:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, got %0h", tag, stg(S-1));
    end else begin
      e = sb.pop_front();
      check({tag, "_vld"}, 128'(outValid[S-1]), 128'(1'b1));
      check(tag, 128'(stg(S-1)), 128'(e));
    end
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = '0; flushAll = 1'b0;
    drive(1'b0, '0);
    tick(); tick();
    check("rst_valid", 128'(outValid), 128'(3'b000));
    check("rst_data", 128'(outData), 128'(0));
    check("rst_retire", 128'(retireCnt), 128'(0));
    check("rst_count", 128'(outCount), 128'(0));
    check("rst_ready", 128'(inReady), 128'(1'b1));
    rst = 1'b1;

    // Stream three bundles back to back.
    drive(1'b1, 29'h1); push(29'h1); tick();
    check("stream_s0", 128'(stg(0)), 128'(29'h1));
    drive(1'b1, 29'h2); push(29'h2); tick();
    drive(1'b1, 29'h3); push(29'h3); tick();
    popCheck("stream_1");
    check("stream_count3", 128'(outCount), 128'(3));
    check("stream_retire0", 128'(retireCnt), 128'(0));
    drive(1'b0, '0); tick();
    popCheck("stream_2");
    check("stream_retire1", 128'(retireCnt), 128'(1));
    tick();
    popCheck("stream_3");
    check("stream_retire2", 128'(retireCnt), 128'(2));
    check("stream_count1", 128'(outCount), 128'(1));
    check("bubble_zero_s0", 128'(stg(0)), 128'(0));
    tick();
    check("stream_retire3", 128'(retireCnt), 128'(3));
    check("stream_count0", 128'(outCount), 128'(0));

    // Fill with C, B, A so that stage 0 = A, then stall stage 1.
    drive(1'b1, C); push(C); tick();
    drive(1'b1, B); push(B); tick();
    drive(1'b1, A); push(A); tick();
    check("fill_retire", 128'(retireCnt), 128'(3));
    popCheck("stall_c");
    drive(1'b1, D); stall = 3'b010; #1;
    check("stall_ready", 128'(inReady), 128'(1'b0));
    tick();
    check("stall_s0", 128'(stg(0)), 128'(A));
    check("stall_s1", 128'(stg(1)), 128'(B));
    check("stall_s2", 128'(stg(2)), 128'(0));
    check("stall_valid", 128'(outValid), 128'(3'b011));
    check("stall_retire", 128'(retireCnt), 128'(4));
    stall = '0; drive(1'b0, '0); tick();
    popCheck("stall_b");
    check("stall_retire_hold", 128'(retireCnt), 128'(4));
    tick();
    popCheck("stall_a");
    check("stall_retire5", 128'(retireCnt), 128'(5));
    tick();
    check("stall_retire6", 128'(retireCnt), 128'(6));

    // Flush wins over stall on stage 0.
    drive(1'b1, 29'h5); tick();
    check("fs_load", 128'(stg(0)), 128'(29'h5));
    drive(1'b0, '0); stall = 3'b001; flush = 3'b001; tick();
    check("fs_valid", 128'(outValid), 128'(3'b000));
    check("fs_data", 128'(outData), 128'(0));
    stall = '0; flush = '0;

    // Stall alone holds stage 0 and leaves a bubble in stage 1.
    drive(1'b1, 29'h7); push(29'h7); tick();
    drive(1'b1, 29'h9); stall = 3'b001; tick();
    check("hold_s0", 128'(stg(0)), 128'(29'h7));
    check("hold_valid", 128'(outValid), 128'(3'b001));
    stall = '0; drive(1'b0, '0); tick(); tick();
    popCheck("hold_7");
    tick();
    check("hold_retire", 128'(retireCnt), 128'(7));

    // Exception flush with every stage valid.
    drive(1'b1, 29'h11); tick();
    drive(1'b1, 29'h12); tick();
    drive(1'b1, 29'h13); tick();
    check("fa_full", 128'(outValid), 128'(3'b111));
    drive(1'b1, 29'h14); flushAll = 1'b1; tick();
    check("fa_valid", 128'(outValid), 128'(3'b000));
    check("fa_data", 128'(outData), 128'(0));
    check("fa_retire", 128'(retireCnt), 128'(7));
    flushAll = 1'b0;

    // Counter wrap; the preload stands in for four billion retirements.
    drive(1'b1, 29'h21); push(29'h21); tick();
    drive(1'b1, 29'h22); push(29'h22); tick();
    drive(1'b0, '0); tick();
    popCheck("wrap_21");
    dut.retireCnt = 32'hFFFF_FFFE;
    tick();
    check("wrap_max", 128'(retireCnt), 128'(32'hFFFF_FFFF));
    popCheck("wrap_22");
    tick();
    check("wrap_zero", 128'(retireCnt), 128'(0));

    // Reset in the middle of a stalled, full pipe.
    drive(1'b1, 29'h31); tick();
    drive(1'b1, 29'h32); tick();
    drive(1'b1, 29'h33); tick();
    drive(1'b1, 29'h34); tick();
    check("mid_retire", 128'(retireCnt), 128'(1));
    rst = 1'b0; stall = 3'b111; flush = 3'b111; tick();
    check("mid_valid", 128'(outValid), 128'(3'b000));
    check("mid_data", 128'(outData), 128'(0));
    check("mid_retire0", 128'(retireCnt), 128'(0));
    check("mid_count", 128'(outCount), 128'(0));
    check("mid_ready_stalled", 128'(inReady), 128'(1'b0));
    stall = '0; flush = '0; #1;
    check("mid_ready", 128'(inReady), 128'(1'b1));
    rst = 1'b1; drive(1'b0, '0); tick();

    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, wanted finish");
    $fatal(1, "timeout");
  end
endmodule
